pipelined_cla_adder: RTL

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: 4-bit lookahead groups,
// GROUPS_PER_STAGE groups resolved per stage, valid/ready handshake with global stall.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW     = 4 * GROUPS_PER_STAGE;
  localparam int unsigned STAGES = WIDTH / SW;

  // Slot 0 is the input register; slot k feeds lookahead stage k.
  logic             vld  [STAGES];
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] bp_q [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic             c_q  [STAGES];

  logic adv;

  // Whole pipeline moves together; it only stalls when a result is held.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Input slot valid bit.
  always_ff @(posedge clk) begin
    if (rst) vld[0] <= 1'b0;
    else if (adv) vld[0] <= in_valid;
  end

  // Input operand capture; subtraction folds into inverted B and carry-in of 1.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      a_q[0]  <= a;
      bp_q[0] <= sub ? ~b : b;
      c_q[0]  <= sub | cin;
      s_q[0]  <= '0;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]               sa, sb, g, p, ss;
    logic [SW:0]                 cc;
    logic [GROUPS_PER_STAGE-1:0] gg, pp;
    logic [GROUPS_PER_STAGE:0]   cg;
    logic [WIDTH-1:0]            s_nxt;

    // Group generate/propagate, cross-group lookahead, then in-group carries and sum bits.
    always_comb begin
      logic term, acc, prod;
      sa    = a_q[k][k*SW +: SW];
      sb    = bp_q[k][k*SW +: SW];
      g     = sa & sb;
      p     = sa ^ sb;
      gg    = '0;
      pp    = '0;
      cg    = '0;
      cc    = '0;
      term  = 1'b0;
      acc   = 1'b0;
      prod  = 1'b0;
      for (int j = 0; j < int'(GROUPS_PER_STAGE); j++) begin
        gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
              | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        pp[j] = &p[4*j +: 4];
      end
      for (int j = 0; j <= int'(GROUPS_PER_STAGE); j++) begin
        term = c_q[k];
        for (int i = 0; i < j; i++) term = term & pp[i];
        acc = term;
        for (int i = 0; i < j; i++) begin
          prod = gg[i];
          for (int m = i + 1; m < j; m++) prod = prod & pp[m];
          acc = acc | prod;
        end
        cg[j] = acc;
      end
      for (int j = 0; j < int'(GROUPS_PER_STAGE); j++) begin
        cc[4*j]   = cg[j];
        cc[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
        cc[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
        cc[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
      end
      cc[SW] = cg[GROUPS_PER_STAGE];
      ss     = p ^ cc[SW-1:0];
      s_nxt  = s_q[k];
      s_nxt[k*SW +: SW] = ss;
    end

    if (k < STAGES - 1) begin : g_mid
      // Stage valid bit.
      always_ff @(posedge clk) begin
        if (rst) vld[k+1] <= 1'b0;
        else if (adv) vld[k+1] <= vld[k];
      end

      // Forward operands, partial sum and stage carry to the next stage.
      always_ff @(posedge clk) begin
        if (adv && vld[k]) begin
          a_q[k+1]  <= a_q[k];
          bp_q[k+1] <= bp_q[k];
          s_q[k+1]  <= s_nxt;
          c_q[k+1]  <= cc[SW];
        end
      end
    end else begin : g_last
      // Output register; results load only from valid slots so bubbles leave it untouched.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (adv) begin
          out_valid <= vld[k];
          if (vld[k]) begin
            sum  <= s_nxt;
            cout <= cc[SW];
            ovf  <= cc[SW] ^ cc[SW-1];
          end
        end
      end
    end
  end

endmodule
